// File: rtl/btn_sel_ctrl_if.sv
// Button inputs and select/enable outputs of the push-button select controller.
// The board/stimulus side drives buttons (master); the controller consumes them (slave).
interface btn_sel_ctrl_if;
  logic       btnU;
  logic       btnD;
  logic       btnL;
  logic       btnR;
  logic       btnC;
  logic [1:0] mux_sel;
  logic [1:0] demux_sel;
  logic       enable;
  logic [4:0] press;

  modport master (
    output btnU, btnD, btnL, btnR, btnC,
    input  mux_sel, demux_sel, enable, press
  );

  modport slave (
    input  btnU, btnD, btnL, btnR, btnC,
    output mux_sel, demux_sel, enable, press
  );
endinterface

// File: rtl/btn_sel_ctrl.sv
// Five-button controller: synchronise, debounce and edge-detect each button, then
// step the mux/demux selects and toggle the path enable on each registered press.
module btn_sel_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic           clk,
  input  logic           rst,
  btn_sel_ctrl_if.slave  bus
);

  localparam int NUM_BTN = 5;
  localparam int CNT_W   = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam int BTN_U = 0;
  localparam int BTN_D = 1;
  localparam int BTN_L = 2;
  localparam int BTN_R = 3;
  localparam int BTN_C = 4;

  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_BTN-1:0] sync1_reg;
  logic [NUM_BTN-1:0] sync2_reg;
  logic [NUM_BTN-1:0] deb_vec;
  logic [NUM_BTN-1:0] deb_prev_reg;
  logic [NUM_BTN-1:0] press_next;
  logic [NUM_BTN-1:0] press_reg;

  logic [1:0] mux_sel_reg;
  logic [1:0] mux_sel_next;
  logic [1:0] demux_sel_reg;
  logic [1:0] demux_sel_next;
  logic       enable_reg;
  logic       enable_next;

  assign btn_raw = {bus.btnC, bus.btnR, bus.btnL, bus.btnD, bus.btnU};

  // Two-flop synchroniser; nothing downstream ever sees the raw pins.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= btn_raw;
      sync2_reg <= sync1_reg;
    end
  end

  // One independent debouncer per button. Any cycle where the synchronised level
  // agrees with the debounced state restarts the count, so short bounces are ignored.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_BTN; gi++) begin : g_lane
      logic             deb_reg;
      logic [CNT_W-1:0] cnt_reg;

      always_ff @(posedge clk) begin
        if (rst) begin
          deb_reg <= 1'b0;
          cnt_reg <= '0;
        end else if (sync2_reg[gi] == deb_reg) begin
          cnt_reg <= '0;
        end else if (cnt_reg == CNT_MAX) begin
          deb_reg <= sync2_reg[gi];
          cnt_reg <= '0;
        end else begin
          cnt_reg <= cnt_reg + CNT_W'(1);
        end
      end

      assign deb_vec[gi] = deb_reg;
    end
  endgenerate

  // Rising edge of the debounced state only; releases are deliberately ignored.
  assign press_next = deb_vec & ~deb_prev_reg;

  always_comb begin
    mux_sel_next   = mux_sel_reg;
    demux_sel_next = demux_sel_reg;
    enable_next    = enable_reg;

    // Opposing presses in the same cycle cancel rather than picking a winner.
    if (press_next[BTN_U] && !press_next[BTN_L]) begin
      mux_sel_next = mux_sel_reg + 2'd1;
    end else if (press_next[BTN_L] && !press_next[BTN_U]) begin
      mux_sel_next = mux_sel_reg - 2'd1;
    end

    if (press_next[BTN_R] && !press_next[BTN_D]) begin
      demux_sel_next = demux_sel_reg + 2'd1;
    end else if (press_next[BTN_D] && !press_next[BTN_R]) begin
      demux_sel_next = demux_sel_reg - 2'd1;
    end

    if (press_next[BTN_C]) begin
      enable_next = ~enable_reg;
    end
  end

  // Press pulses and the state they act on are registered on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      deb_prev_reg  <= '0;
      press_reg     <= '0;
      mux_sel_reg   <= 2'b00;
      demux_sel_reg <= 2'b00;
      enable_reg    <= 1'b1;
    end else begin
      deb_prev_reg  <= deb_vec;
      press_reg     <= press_next;
      mux_sel_reg   <= mux_sel_next;
      demux_sel_reg <= demux_sel_next;
      enable_reg    <= enable_next;
    end
  end

  assign bus.mux_sel   = mux_sel_reg;
  assign bus.demux_sel = demux_sel_reg;
  assign bus.enable    = enable_reg;
  assign bus.press     = press_reg;

endmodule

// File: tb/tb_btn_sel_ctrl.sv
// Directed bench for btn_sel_ctrl with DEBOUNCE_CYCLES=4: a button raised just after
// edge e is first sampled at e+1 and its press lands on edge e+7.
module tb_btn_sel_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   pulse_cnt = 0;

  btn_sel_ctrl_if bus ();

  btn_sel_ctrl #(.DEBOUNCE_CYCLES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000 ns");
    $fatal(1, "timeout");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (bus.press != 5'b0) pulse_cnt++;
    end
  endtask

  task automatic set_btn(input logic [4:0] b);
    {bus.btnC, bus.btnR, bus.btnL, bus.btnD, bus.btnU} = b;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [1:0] m, input logic [1:0] d,
                         input logic e);
    chk({tag, "_mux"},   bus.mux_sel,   m);
    chk({tag, "_demux"}, bus.demux_sel, d);
    chk({tag, "_en"},    bus.enable,    e);
  endtask

  // Press b cleanly, hold well past the debounce, release and let it settle.
  task automatic do_press(input string tag, input logic [4:0] b,
                          input logic [1:0] m, input logic [1:0] d, input logic e);
    pulse_cnt = 0;
    set_btn(b);
    tick(6);
    chk({tag, "_early"}, bus.press, 5'b0);
    tick(1);
    chk({tag, "_press"}, bus.press, b);
    chk_out(tag, m, d, e);
    tick(1);
    chk({tag, "_one"}, bus.press, 5'b0);
    tick(12);
    set_btn(5'b0);
    tick(8);
    chk({tag, "_pulses"}, pulse_cnt, 1);
    chk_out({tag, "_hold"}, m, d, e);
    $display("[TB] %s: press=%b mux=%0d demux=%0d en=%0d", tag, b,
             bus.mux_sel, bus.demux_sel, bus.enable);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  initial begin
    set_btn(5'b0);
    tick(2);
    chk({"reset", "_press"}, bus.press, 5'b0);
    chk_out("reset", 2'd0, 2'd0, 1'b1);
    rst = 1'b0;
    $display("[TB] reset: mux=%0d demux=%0d en=%0d", bus.mux_sel, bus.demux_sel, bus.enable);

    // Up five times wraps 3 -> 0.
    do_press("u1", 5'b00001, 2'd1, 2'd0, 1'b1);
    do_press("u2", 5'b00001, 2'd2, 2'd0, 1'b1);
    do_press("u3", 5'b00001, 2'd3, 2'd0, 1'b1);
    do_press("u4", 5'b00001, 2'd0, 2'd0, 1'b1);
    do_press("u5", 5'b00001, 2'd1, 2'd0, 1'b1);

    do_reset();
    chk_out("rst2", 2'd0, 2'd0, 1'b1);
    do_press("l_wrap", 5'b00100, 2'd3, 2'd0, 1'b1);
    do_press("d_wrap", 5'b00010, 2'd3, 2'd3, 1'b1);
    do_press("c1",     5'b10000, 2'd3, 2'd3, 1'b0);
    do_press("c2",     5'b10000, 2'd3, 2'd3, 1'b1);

    // Bouncing R: 2 high, 1 low, 3 high, 1 low, then held 10.
    pulse_cnt = 0;
    set_btn(5'b01000); tick(2);
    set_btn(5'b00000); tick(1);
    set_btn(5'b01000); tick(3);
    set_btn(5'b00000); tick(1);
    chk("bounce_none", pulse_cnt, 0);
    set_btn(5'b01000);
    tick(6);
    chk("bounce_early", bus.press, 5'b0);
    tick(1);
    chk("bounce_press", bus.press, 5'b01000);
    chk_out("bounce", 2'd3, 2'd0, 1'b1);
    tick(3);
    set_btn(5'b0);
    tick(8);
    chk("bounce_pulses", pulse_cnt, 1);
    chk_out("bounce_end", 2'd3, 2'd0, 1'b1);
    $display("[TB] bounce_r: demux=%0d pulses=%0d", bus.demux_sel, pulse_cnt);

    // Opposing U+L cancel; R+C act independently.
    do_press("ul", 5'b00101, 2'd3, 2'd0, 1'b1);
    do_press("rc", 5'b11000, 2'd3, 2'd1, 1'b0);

    // Reset in the middle of a U debounce with U still held.
    set_btn(5'b00001);
    tick(4);
    rst = 1'b1;
    pulse_cnt = 0;
    tick(2);
    chk({"midrst", "_press"}, bus.press, 5'b0);
    chk_out("midrst", 2'd0, 2'd0, 1'b1);
    rst = 1'b0;
    tick(6);
    chk("midrst_early", bus.press, 5'b0);
    chk("midrst_mux0", bus.mux_sel, 2'd0);
    tick(1);
    chk("midrst_press", bus.press, 5'b00001);
    chk("midrst_mux1", bus.mux_sel, 2'd1);
    tick(10);
    chk("midrst_pulses", pulse_cnt, 1);
    chk("midrst_hold", bus.mux_sel, 2'd1);
    set_btn(5'b0);
    tick(8);
    $display("[TB] midrst: mux=%0d pulses=%0d", bus.mux_sel, pulse_cnt);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
